// File: rtl/instr_encoder_if.sv
// Valid/ready bundle between the program loader, the instruction encoder and
// the instruction-memory write port.
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [4:0] in_opcode;
  logic [2:0] in_reg1;
  logic [2:0] in_reg2;
  logic [7:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_code;
  logic       out_mode;

  modport master (
    output in_valid, in_mode, in_opcode, in_reg1, in_reg2, in_imm, out_ready,
    input  in_ready, out_valid, out_code, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_opcode, in_reg1, in_reg2, in_imm, out_ready,
    output in_ready, out_valid, out_code, out_mode
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes decoded instruction fields into 9-bit words, inserting a mode-toggle
// word (9'h000) whenever the requested mode differs from the decoder's mode.
module instr_encoder #(
  parameter logic INIT_MODE = 1'b0,
  parameter int   CNTW      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus,
  output logic            err,
  output logic            cur_mode,
  output logic [CNTW-1:0] tog_cnt
);

  typedef enum logic [1:0] {IDLE, TOG, INS} state_t;

  state_t     state, nstate;
  logic [8:0] word;
  logic       wmode;
  logic       legal, immok, idle_fire;
  logic [2:0] immcode;
  logic [8:0] enc;

  // Immediate must be one of the eight representable values.
  always_comb begin
    immok   = 1'b1;
    immcode = 3'd0;
    case (bus.in_imm)
      8'd0:    immcode = 3'd0;
      8'd1:    immcode = 3'd1;
      8'd4:    immcode = 3'd2;
      8'd8:    immcode = 3'd3;
      8'd16:   immcode = 3'd4;
      8'd32:   immcode = 3'd5;
      8'd64:   immcode = 3'd6;
      8'd127:  immcode = 3'd7;
      default: immok   = 1'b0;
    endcase
  end

  always_comb begin
    if (bus.in_mode) begin
      legal = (bus.in_opcode[4:3] == 2'b00) && (bus.in_opcode[2:0] != 3'd0) && immok;
      enc   = {bus.in_opcode[2:0], bus.in_reg1, immcode};
    end else begin
      // opcode 0 is reserved for the toggle word itself
      legal = (bus.in_opcode != 5'd0) && !bus.in_reg1[2] && !bus.in_reg2[2];
      enc   = {bus.in_opcode, bus.in_reg1[1:0], bus.in_reg2[1:0]};
    end
  end

  assign idle_fire = bus.in_valid && (state == IDLE);

  always_comb begin
    nstate        = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_code  = word;
    bus.out_mode  = wmode;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (idle_fire && legal)
          nstate = (bus.in_mode != cur_mode) ? TOG : INS;
      end
      TOG: begin
        bus.out_valid = 1'b1;
        bus.out_code  = 9'h000;
        bus.out_mode  = cur_mode;
        if (bus.out_ready) nstate = INS;
      end
      INS: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_mode <= INIT_MODE;
      word     <= 9'h000;
      wmode    <= INIT_MODE;
      err      <= 1'b0;
      tog_cnt  <= '0;
    end else begin
      state <= nstate;
      err   <= idle_fire && !legal;
      if (idle_fire && legal) begin
        word  <= enc;
        wmode <= bus.in_mode;
      end
      if (state == TOG && bus.out_ready) begin
        cur_mode <= ~cur_mode;
        if (!(&tog_cnt)) tog_cnt <= tog_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + randomized bench for instr_encoder against a field-level model.
module tb_instr_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_a, cur_mode_a, err_b, cur_mode_b;
  logic [1:0] tog_cnt_a;
  logic [7:0] tog_cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  bit m_mode;
  int m_tog;
  logic [7:0] imm_tab [8] = '{8'd0, 8'd1, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd127};

  instr_encoder_if ifa ();
  instr_encoder_if ifb ();

  always #5 clk = ~clk;

  instr_encoder #(.INIT_MODE(1'b0), .CNTW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .err(err_a), .cur_mode(cur_mode_a), .tog_cnt(tog_cnt_a));

  // Second copy in lockstep with the default counter width.
  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_mode   = ifa.in_mode;
  assign ifb.in_opcode = ifa.in_opcode;
  assign ifb.in_reg1   = ifa.in_reg1;
  assign ifb.in_reg2   = ifa.in_reg2;
  assign ifb.in_imm    = ifa.in_imm;
  assign ifb.out_ready = ifa.out_ready;

  instr_encoder dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .err(err_b), .cur_mode(cur_mode_b), .tog_cnt(tog_cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int imm_code(input logic [7:0] im);
    imm_code = -1;
    for (int i = 0; i < 8; i++) if (imm_tab[i] == im) imm_code = i;
  endfunction

  function automatic bit m_legal(input bit md, input int op, input int r1, input int r2,
                                 input logic [7:0] im);
    if (md) m_legal = (op >= 1) && (op <= 7) && (imm_code(im) >= 0);
    else    m_legal = (op != 0) && (r1 < 4) && (r2 < 4);
  endfunction

  function automatic logic [8:0] m_enc(input bit md, input int op, input int r1, input int r2,
                                       input logic [7:0] im);
    int v;
    if (md) v = op * 64 + r1 * 8 + imm_code(im);
    else    v = op * 16 + (r1 % 4) * 4 + (r2 % 4);
    m_enc = 9'(v);
  endfunction

  function automatic int sat3(input int v);
    sat3 = (v > 3) ? 3 : v;
  endfunction

  task automatic drive(input bit md, input logic [4:0] op, input logic [2:0] r1,
                       input logic [2:0] r2, input logic [7:0] im);
    ifa.in_valid  = 1'b1;
    ifa.in_mode   = md;
    ifa.in_opcode = op;
    ifa.in_reg1   = r1;
    ifa.in_reg2   = r2;
    ifa.in_imm    = im;
  endtask

  task automatic scramble();
    ifa.in_valid  = 1'b0;
    ifa.in_mode   = 1'($urandom);
    ifa.in_opcode = 5'($urandom);
    ifa.in_reg1   = 3'($urandom);
    ifa.in_reg2   = 3'($urandom);
    ifa.in_imm    = 8'($urandom);
  endtask

  task automatic send(input bit md, input logic [4:0] op, input logic [2:0] r1,
                      input logic [2:0] r2, input logic [7:0] im, input bit bp);
    logic [8:0] qw[$];
    bit qm[$];
    bit rdy;
    int stall, guard;
    chk("in_ready_idle", 32'(ifa.in_ready), 32'd1);
    drive(md, op, r1, r2, im);
    @(posedge clk); #1;
    scramble();
    if (!m_legal(md, op, r1, r2, im)) begin
      chk("err_pulse", 32'(err_a), 32'd1);
      chk("err_no_out", 32'(ifa.out_valid), 32'd0);
      chk("err_mode", 32'(cur_mode_a), 32'(m_mode));
      @(posedge clk); #1;
      chk("err_clear", 32'(err_a), 32'd0);
      chk("err_no_out2", 32'(ifa.out_valid), 32'd0);
      return;
    end
    if (md != m_mode) begin qw.push_back(9'h000); qm.push_back(m_mode); end
    qw.push_back(m_enc(md, op, r1, r2, im));
    qm.push_back(md);
    stall = 0;
    guard = 0;
    while (qw.size() > 0 && guard < 40) begin
      guard++;
      chk("out_valid", 32'(ifa.out_valid), 32'd1);
      chk("out_code", 32'(ifa.out_code), 32'(qw[0]));
      chk("out_mode", 32'(ifa.out_mode), 32'(qm[0]));
      chk("no_accept", 32'(ifa.in_ready), 32'd0);
      rdy = !bp || ($urandom_range(2) != 0) || (stall >= 4);
      ifa.out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) begin
        if (qw[0] == 9'h000) begin m_mode = ~m_mode; m_tog++; end
        void'(qw.pop_front());
        void'(qm.pop_front());
        stall = 0;
      end else stall++;
    end
    chk("drain_bound", 32'(qw.size()), 32'd0);
    ifa.out_ready = 1'b1;
    chk("done_valid", 32'(ifa.out_valid), 32'd0);
    chk("done_ready", 32'(ifa.in_ready), 32'd1);
    chk("cur_mode", 32'(cur_mode_a), 32'(m_mode));
    chk("tog_cnt_sat", 32'(tog_cnt_a), 32'(sat3(m_tog)));
    chk("tog_cnt_wide", 32'(tog_cnt_b), 32'(m_tog % 256));
    chk("no_err", 32'(err_a), 32'd0);
  endtask

  initial begin
    logic [8:0] w;
    bit md;
    scramble();
    ifa.out_ready = 1'b1;
    m_mode = 1'b0;
    m_tog = 0;
    #12;
    chk("rst_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_code", 32'(ifa.out_code), 32'd0);
    chk("rst_omode", 32'(ifa.out_mode), 32'd0);
    chk("rst_mode", 32'(cur_mode_a), 32'd0);
    chk("rst_tog", 32'(tog_cnt_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain mode-0 word, then a mode-1 word that needs a toggle
    send(1'b0, 5'b00011, 3'd2, 3'd1, 8'd0, 1'b0);
    chk("enc_m0", 32'(m_enc(1'b0, 3, 2, 1, 8'd0)), 32'h039);
    send(1'b1, 5'b00101, 3'd6, 3'd0, 8'd16, 1'b0);

    // Illegal field combinations
    send(1'b1, 5'b00101, 3'd1, 3'd0, 8'd5, 1'b0);
    send(1'b0, 5'b00000, 3'd1, 3'd1, 8'd0, 1'b0);
    send(1'b0, 5'b00010, 3'd4, 3'd1, 8'd0, 1'b0);
    send(1'b1, 5'b01001, 3'd1, 3'd0, 8'd4, 1'b0);
    chk("illegal_keep_mode", 32'(cur_mode_a), 32'd1);

    // Backpressure while the toggle word is pending
    md = ~m_mode;
    w = m_enc(md, 2, 3, 1, 8'd64);
    ifa.out_ready = 1'b0;
    drive(md, 5'd2, 3'd3, 3'd1, 8'd64);
    @(posedge clk); #1;
    scramble();
    repeat (4) begin
      chk("stall_valid", 32'(ifa.out_valid), 32'd1);
      chk("stall_code", 32'(ifa.out_code), 32'd0);
      chk("stall_omode", 32'(ifa.out_mode), 32'(m_mode));
      chk("stall_ready", 32'(ifa.in_ready), 32'd0);
      chk("stall_mode", 32'(cur_mode_a), 32'(m_mode));
      @(posedge clk); #1;
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    m_mode = ~m_mode;
    m_tog++;
    chk("stall_flip", 32'(cur_mode_a), 32'(m_mode));
    chk("stall_word", 32'(ifa.out_code), 32'(w));
    chk("stall_wmode", 32'(ifa.out_mode), 32'(md));
    @(posedge clk); #1;
    chk("stall_done", 32'(ifa.out_valid), 32'd0);

    // Asynchronous reset in INS right after a toggle
    if (m_mode) send(1'b0, 5'd1, 3'd0, 3'd0, 8'd0, 1'b0);
    drive(1'b1, 5'd5, 3'd6, 3'd0, 8'd16);
    @(posedge clk); #1;
    scramble();
    chk("pre_rst_tog", 32'(ifa.out_code), 32'd0);
    @(posedge clk); #1;
    chk("pre_rst_mode", 32'(cur_mode_a), 32'd1);
    chk("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifa.out_valid), 32'd0);
    chk("arst_mode", 32'(cur_mode_a), 32'd0);
    chk("arst_tog", 32'(tog_cnt_a), 32'd0);
    chk("arst_ready", 32'(ifa.in_ready), 32'd1);
    m_mode = 1'b0;
    m_tog = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 5'b10110, 3'd3, 3'd2, 8'd0, 1'b0);

    // Saturation of the 2-bit counter with alternating modes
    for (int i = 0; i < 5; i++)
      send(~m_mode, 5'd3, 3'd1, 3'd2, 8'd127, 1'b0);
    chk("sat_a", 32'(tog_cnt_a), 32'd3);
    chk("sat_b", 32'(tog_cnt_b), 32'd5);

    // Randomized fields with random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [7:0] im;
      im = ($urandom_range(4) != 0) ? imm_tab[$urandom_range(7)] : 8'($urandom);
      send(1'($urandom), 5'($urandom_range(9)), 3'($urandom_range(4)),
           3'($urandom_range(4)), im, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Converts decoded instruction fields (opcode, registers, immediate, addressing mode) into 9-bit machine words for the 9-bit ISA decoder.
- Tracks the decoder's mode flip-flop. Automatically inserts a mode-toggle word (9'h000) before any instruction whose mode differs from the current mode.
- Sits between the program generator/loader and instruction memory write port; valid/ready on both sides.

Parameters:
- INIT_MODE, 1'b0, mode tracker value after reset (0 = reg-reg, 1 = reg-immediate).
- CNTW, 8, width of the saturating inserted-toggle counter.

Ports:
- Clk  input  1  clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept fields.
- in_mode  input  1  required mode: 0 reg-reg, 1 reg-immediate.
- in_opcode  input  5  opcode; only [2:0] used in mode 1.
- in_reg1  input  3  first register; only [1:0] used in mode 0.
- in_reg2  input  3  second register (mode 0 only; ignored in mode 1).
- in_imm  input  8  immediate value (mode 1 only).
- out_valid  output  1  out_code valid.
- out_ready  input  1  downstream accepts out_code.
- out_code  output  9  machine word.
- out_mode  output  1  decoder mode in which out_code is interpreted (mode before toggle for toggle words).
- err  output  1  one-cycle pulse: accepted fields not encodable, dropped.
- cur_mode  output  1  tracked decoder mode.
- tog_cnt  output  CNTW  number of toggle words emitted, saturating.

Behaviour:
- States: IDLE, TOG, INS.
- Reset values: state=IDLE, cur_mode=INIT_MODE, out_valid=0, out_code=0, out_mode=INIT_MODE, err=0, tog_cnt=0, in_ready=1.
- in_ready = (state==IDLE). Handshake fires on in_valid & in_ready. out transfer fires on out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_code and out_mode hold stable.
- Legality, mode 0:
  - in_opcode != 0 (opcode 00000 is the toggle).
  - in_reg1[2]==0 and in_reg2[2]==0.
- Legality, mode 1:
  - in_opcode[4:3]==0 and in_opcode[2:0] != 0.
  - in_imm must be one of 0,1,4,8,16,32,64,127, mapped to codes 0..7 in that order.
- Encoding:
  - Mode 0: {opcode[4:0], reg1[1:0], reg2[1:0]}.
  - Mode 1: {opcode[2:0], reg1[2:0], immcode[2:0]}.
  - Toggle word: 9'h000 in either mode.
- IDLE, on handshake:
  - Illegal: err=1 next cycle for exactly one cycle; nothing emitted; stay IDLE.
  - Legal: latch fields and encoded word. Go to TOG if in_mode != cur_mode, else INS.
- TOG: out_valid=1, out_code=9'h000, out_mode=cur_mode. On transfer: cur_mode inverts, tog_cnt increments (holds at all-ones), go INS.
- INS: out_valid=1, out_code=latched word, out_mode=latched mode (== cur_mode). On transfer: go IDLE, out_valid drops next cycle.
- Latency:
  - Handshake at edge N gives first word valid in cycle N+1.
  - Without toggle and with out_ready held 1: one instruction per 2 cycles.
  - With toggle and out_ready held 1: one instruction per 3 cycles.
- Input fields are sampled only at handshake; later changes have no effect.
- Reset asserted mid-TOG/INS: immediately returns to reset values. The pending word is lost and cur_mode returns to INIT_MODE even if a toggle was already emitted.
- err and a legal acceptance cannot coincide (one handshake per acceptance).

Test Plan:
- Reset with INIT_MODE=0; send mode0 op=5'b00011, reg1=2, reg2=1, out_ready=1 -> single word 9'b00011_10_01 one cycle after handshake, tog_cnt=0, cur_mode=0.
- Send mode1 op=3'b101, reg1=6, imm=16 from cur_mode=0 -> words 9'h000 (out_mode=0) then 9'b101_110_100 (out_mode=1); cur_mode=1, tog_cnt=1.
- Illegal inputs, each rejected: mode1 imm=5; mode0 op=0; mode0 reg1=4; mode1 op=5'b01001 -> err one-cycle pulse each, out_valid stays 0, cur_mode unchanged.
- out_ready held 0 for 4 cycles during TOG -> out_code stays 9'h000 and in_ready stays 0; cur_mode flips only on the transfer cycle.
- Drive Reset low while in INS after a toggle (cur_mode=1) -> out_valid=0, cur_mode=0, tog_cnt=0 asynchronously; next legal mode0 instruction is emitted with no toggle.
- CNTW=2; force 5 alternating-mode instructions -> tog_cnt saturates at 3, all toggle words still emitted.
